// File: rtl/reset_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and counter sizing.
package reset_pkg;

  localparam logic [1:0] ST_ASSERT  = 2'd0;
  localparam logic [1:0] ST_STRETCH = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [1:0] ST_RUN     = 2'd3;

  // Bits needed to hold the larger of two terminal counts.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Async-assert / sync-deassert reset synchronizer, SYNC_STAGES flops deep.
module reset_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_async,
  output logic rst_sync
);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("reset_sync: SYNC_STAGES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) stages <= '1;
    else           stages <= {stages[SYNC_STAGES-2:0], 1'b0};
  end

  assign rst_sync = stages[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Produces ordered synchronous resets from a board-level async reset, with
// stretch, staggered release and a software-requested reset with acknowledge.
//
// state      | meaning
// ASSERT     | all outputs asserted, waiting for synchronized release
// STRETCH    | all outputs asserted, counting STRETCH_CYCLES (hold restarts)
// RELEASE    | deasserting rst_out bits one per STAGE_GAP cycles
// RUN        | all outputs released, ready high, accepting sw_rst_req
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 16,
  parameter int NUM_OUT        = 3,
  parameter int STAGE_GAP      = 4
) (
  input  logic               clk,
  input  logic               rst_async,
  input  logic               sw_rst_req,
  input  logic               hold,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               ready,
  output logic               sw_rst_ack
);

  if (STRETCH_CYCLES < 1) begin : g_bad_stretch
    $error("reset_sequencer: STRETCH_CYCLES must be >= 1");
  end
  if (NUM_OUT < 1) begin : g_bad_num_out
    $error("reset_sequencer: NUM_OUT must be >= 1");
  end
  if (STAGE_GAP < 1) begin : g_bad_gap
    $error("reset_sequencer: STAGE_GAP must be >= 1");
  end

  localparam int CW = cnt_width(STRETCH_CYCLES, STAGE_GAP);
  localparam int IW = $clog2(NUM_OUT + 1);
  localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_OUT - 1);

  logic          rst_int;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          sw_pending;

  reset_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst_async(rst_async),
    .rst_sync (rst_int)
  );

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state      <= ST_ASSERT;
      cnt        <= '0;
      idx        <= '0;
      rst_out    <= '1;
      ready      <= 1'b0;
      sw_rst_ack <= 1'b0;
      sw_pending <= 1'b0;
    end else begin
      sw_rst_ack <= 1'b0;
      case (state)
        // The edge that leaves ASSERT is the first stretch cycle, so the
        // power-on release lands SYNC_STAGES + STRETCH_CYCLES edges out.
        ST_ASSERT, ST_STRETCH: begin
          if (state == ST_STRETCH || !rst_int) begin
            if (hold) begin
              state <= ST_STRETCH;
              cnt   <= '0;
            end else if (cnt == STRETCH_LAST) begin
              rst_out[0] <= 1'b0;
              cnt        <= '0;
              idx        <= IW'(1);
              if (NUM_OUT == 1) begin
                state      <= ST_RUN;
                ready      <= 1'b1;
                sw_rst_ack <= sw_pending;
                sw_pending <= 1'b0;
              end else begin
                state <= ST_RELEASE;
              end
            end else begin
              state <= ST_STRETCH;
              cnt   <= cnt + 1'b1;
            end
          end
        end
        ST_RELEASE: begin
          if (cnt == GAP_LAST) begin
            rst_out <= rst_out & ~(NUM_OUT'(1) << idx);
            idx     <= idx + 1'b1;
            cnt     <= '0;
            if (idx == IDX_LAST) begin
              state      <= ST_RUN;
              ready      <= 1'b1;
              sw_rst_ack <= sw_pending;
              sw_pending <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (sw_rst_req) begin
            rst_out    <= '1;
            ready      <= 1'b0;
            sw_pending <= 1'b1;
            cnt        <= '0;
            state      <= ST_STRETCH;
          end
        end
        default: state <= ST_ASSERT;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: table-driven power-on/software
// sequences plus hand-written hold, abort, ignored-request and minimal-config cases.
module tb_reset_sequencer;

  typedef struct {
    logic       sw;
    logic       hold;
    logic [2:0] out;
    logic       rdy;
    logic       ack;
  } vec_t;

  typedef struct {
    logic [2:0] out;
    logic       rdy;
    logic       ack;
    string      tag;
  } exp_t;

  logic clk;
  logic rst_async_a, sw_a, hold_a, ready_a, ack_a;
  logic [2:0] rst_out_a;
  logic rst_async_b, sw_b, hold_b, ready_b, ack_b;
  logic [0:0] rst_out_b;

  int checks = 0;
  int errors = 0;
  vec_t vecs[22];
  exp_t sb[$];

  reset_sequencer #(.SYNC_STAGES(2), .STRETCH_CYCLES(4), .NUM_OUT(3), .STAGE_GAP(2)) dut_a (
    .clk(clk), .rst_async(rst_async_a), .sw_rst_req(sw_a), .hold(hold_a),
    .rst_out(rst_out_a), .ready(ready_a), .sw_rst_ack(ack_a)
  );

  reset_sequencer #(.SYNC_STAGES(2), .STRETCH_CYCLES(1), .NUM_OUT(1), .STAGE_GAP(1)) dut_b (
    .clk(clk), .rst_async(rst_async_b), .sw_rst_req(sw_b), .hold(hold_b),
    .rst_out(rst_out_b), .ready(ready_b), .sw_rst_ack(ack_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic sw, input logic hold, input logic [2:0] out,
                              input logic rdy, input logic ack);
    vec_t v;
    v.sw = sw; v.hold = hold; v.out = out; v.rdy = rdy; v.ack = ack;
    return v;
  endfunction

  task automatic cmp(input string tag, input logic [2:0] act, input logic [2:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b at %0t", tag, act, expv, $time);
    end
  endtask

  // Called just after a negedge: drive, record expectation, sample #1 after posedge.
  task automatic step(input bit use_b, input logic sw, input logic hold, input logic [2:0] out,
                      input logic rdy, input logic ack, input string tag);
    exp_t e;
    logic [2:0] act_out;
    logic act_rdy, act_ack;
    if (use_b) begin sw_b = sw; hold_b = hold; end
    else       begin sw_a = sw; hold_a = hold; end
    e.out = out; e.rdy = rdy; e.ack = ack; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (use_b) begin act_out = {2'b00, rst_out_b}; act_rdy = ready_b; act_ack = ack_b; end
    else       begin act_out = rst_out_a;          act_rdy = ready_a; act_ack = ack_a; end
    cmp({e.tag, "_rst_out"}, act_out, e.out);
    cmp({e.tag, "_ready"}, {2'b00, act_rdy}, {2'b00, e.rdy});
    cmp({e.tag, "_ack"}, {2'b00, act_ack}, {2'b00, e.ack});
    @(negedge clk);
  endtask

  task automatic replay(input int first, input int last, input int sw_from, input int sw_to,
                        input string tag);
    for (int i = first; i <= last; i++)
      step(0, (i >= sw_from && i <= sw_to), vecs[i].hold, vecs[i].out, vecs[i].rdy, vecs[i].ack, tag);
  endtask

  initial begin
    // Power-on: entry i is edge E(i+1) after rst_async falls.
    for (int i = 0; i < 5; i++) vecs[i] = mk(0, 0, 3'b111, 0, 0);
    vecs[5]  = mk(0, 0, 3'b110, 0, 0);
    vecs[6]  = mk(0, 0, 3'b110, 0, 0);
    vecs[7]  = mk(0, 0, 3'b100, 0, 0);
    vecs[8]  = mk(0, 0, 3'b100, 0, 0);
    vecs[9]  = mk(0, 0, 3'b000, 1, 0);
    vecs[10] = mk(0, 0, 3'b000, 1, 0);
    // Software request at S = entry 11.
    vecs[11] = mk(1, 0, 3'b111, 0, 0);
    for (int i = 12; i < 15; i++) vecs[i] = mk(0, 0, 3'b111, 0, 0);
    vecs[15] = mk(0, 0, 3'b110, 0, 0);
    vecs[16] = mk(0, 0, 3'b110, 0, 0);
    vecs[17] = mk(0, 0, 3'b100, 0, 0);
    vecs[18] = mk(0, 0, 3'b100, 0, 0);
    vecs[19] = mk(0, 0, 3'b000, 1, 1);
    vecs[20] = mk(0, 0, 3'b000, 1, 0);
    vecs[21] = mk(0, 0, 3'b000, 1, 0);

    rst_async_a = 1'b1; sw_a = 1'b0; hold_a = 1'b0;
    rst_async_b = 1'b1; sw_b = 1'b0; hold_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp("reset_a_rst_out", rst_out_a, 3'b111);
    cmp("reset_a_ready", {2'b00, ready_a}, 3'b000);
    cmp("reset_a_ack", {2'b00, ack_a}, 3'b000);
    cmp("reset_b_rst_out", {2'b00, rst_out_b}, 3'b001);
    cmp("reset_b_ready", {2'b00, ready_b}, 3'b000);
    @(negedge clk);

    // Power-on sequence followed by a one-cycle software request.
    rst_async_a = 1'b0;
    for (int i = 0; i < 22; i++)
      step(0, vecs[i].sw, vecs[i].hold, vecs[i].out, vecs[i].rdy, vecs[i].ack,
           (i < 11) ? "s1_po" : "s2_sw");

    // hold for 5 cycles mid-STRETCH restarts the full stretch count.
    step(0, 1, 0, 3'b111, 0, 0, "s3_req");
    step(0, 0, 0, 3'b111, 0, 0, "s3_cnt");
    repeat (5) step(0, 0, 1, 3'b111, 0, 0, "s3_hold");
    repeat (3) step(0, 0, 0, 3'b111, 0, 0, "s3_restretch");
    step(0, 0, 0, 3'b110, 0, 0, "s3_rel0");
    step(0, 0, 0, 3'b110, 0, 0, "s3_gap");
    step(0, 0, 0, 3'b100, 0, 0, "s3_rel1");

    // Asynchronous abort between edges while rst_out = 100 and an ack is pending.
    rst_async_a = 1'b1;
    #1;
    cmp("s4_async_rst_out", rst_out_a, 3'b111);
    cmp("s4_async_ready", {2'b00, ready_a}, 3'b000);
    step(0, 0, 0, 3'b111, 0, 0, "s4_held");
    rst_async_a = 1'b0;
    replay(0, 10, -1, -1, "s4_po");
    step(0, 0, 0, 3'b000, 1, 0, "s4_noack");

    // Request high during STRETCH/RELEASE only: ignored, no ack.
    rst_async_a = 1'b1;
    step(0, 0, 0, 3'b111, 0, 0, "s5_rst");
    rst_async_a = 1'b0;
    replay(0, 10, 3, 7, "s5a_po");
    step(0, 0, 0, 3'b000, 1, 0, "s5a_idle");

    // Request held through entry to RUN: new sequence on the first RUN edge.
    rst_async_a = 1'b1;
    step(0, 0, 0, 3'b111, 0, 0, "s5_rst");
    rst_async_a = 1'b0;
    replay(0, 9, 3, 9, "s5b_po");
    step(0, 1, 0, 3'b111, 0, 0, "s5b_new");
    replay(12, 21, -1, -1, "s5b_sw");

    // Minimal configuration: release on E3, back-to-back software requests.
    rst_async_b = 1'b0;
    step(1, 0, 0, 3'b001, 0, 0, "s6_e1");
    step(1, 0, 0, 3'b001, 0, 0, "s6_e2");
    step(1, 0, 0, 3'b000, 1, 0, "s6_e3");
    step(1, 0, 0, 3'b000, 1, 0, "s6_run");
    step(1, 1, 0, 3'b001, 0, 0, "s6_req1");
    step(1, 0, 0, 3'b000, 1, 1, "s6_ack1");
    step(1, 1, 0, 3'b001, 0, 0, "s6_req2");
    step(1, 0, 0, 3'b000, 1, 1, "s6_ack2");
    step(1, 0, 0, 3'b000, 1, 0, "s6_idle");

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    checks++;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
